// File: rtl/reg_file.sv
// Y86-64 program register file: fifteen DATA_W-bit registers, two write ports (E, M),
// two combinational read ports (A, B) with optional write-to-read bypass, a debug port and a write counter.
module reg_file #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter bit                BYPASS   = 1'b1,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_val,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [3:0] NONE   = 4'hF;
    localparam int         NREG   = 15;
    localparam int         RSP_ID = 4;

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  count;
    logic              we_e;
    logic              we_m;
    logic [1:0]        n_wr;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] acc,
        input logic [1:0]       inc
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W])
            sat_add = '1;
        else
            sat_add = sum[CNT_W-1:0];
    endfunction

    // M wins on a shared destination, so E is suppressed there (popq %rsp)
    function automatic logic [DATA_W-1:0] forward(
        input logic [3:0]        src,
        input logic [DATA_W-1:0] stored,
        input logic              e_live,
        input logic [3:0]        e_dst,
        input logic [DATA_W-1:0] e_val,
        input logic              m_live,
        input logic [3:0]        m_dst,
        input logic [DATA_W-1:0] m_val
    );
        if (BYPASS && m_live && (m_dst == src))
            forward = m_val;
        else if (BYPASS && e_live && (e_dst == src))
            forward = e_val;
        else
            forward = stored;
    endfunction

    assign we_m = wb_en && (dstM != NONE);
    assign we_e = wb_en && (dstE != NONE) && (dstE != dstM);
    assign n_wr = {1'b0, we_e} + {1'b0, we_m};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == RSP_ID) ? RSP_INIT : '0;
            count <= '0;
        end else begin
            if (we_m)
                regs[dstM] <= valM;
            if (we_e)
                regs[dstE] <= valE;
            count <= sat_add(count, n_wr);
        end
    end

    assign stored_a = (srcA == NONE) ? '0 : regs[srcA];
    assign stored_b = (srcB == NONE) ? '0 : regs[srcB];

    assign valA     = forward(srcA, stored_a, we_e, dstE, valE, we_m, dstM, valM);
    assign valB     = forward(srcB, stored_b, we_e, dstE, valE, we_m, dstM, valM);
    assign dbg_val  = (dbg_sel == NONE) ? '0 : regs[dbg_sel];
    assign wr_count = count;

endmodule
